// File: rtl/amstrad_scandoubler_if.sv
// Amstrad video stream bundle: one pixel enable, 2-bit RGB and active-high
// sync/blank flags. The scan doubler receives one of these (slave) and
// drives another (master).
//   ce_pix            pixel enable (one clk pulse per pixel)
//   red/green/blue    2-bit colour components
//   hsync/vsync       sync pulses, active-high
//   hblank/vblank     blanking flags, active-high
interface amstrad_scandoubler_if;
    logic       ce_pix;
    logic [1:0] red;
    logic [1:0] green;
    logic [1:0] blue;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;

    modport master (
        output ce_pix, red, green, blue, hsync, vsync, hblank, vblank
    );

    modport slave (
        input ce_pix, red, green, blue, hsync, vsync, hblank, vblank
    );
endinterface

// File: rtl/amstrad_scandoubler.sv
// Line-doubling scan converter for the Amstrad video outputs. Each 15 kHz
// input line is captured into one bank of a two-bank line buffer while the
// other bank (the previous line) is replayed twice at the doubled pixel rate.
// With enable low the input stream is passed through, registered on ce_pix.
//   clk      system clock
//   reset    asynchronous, active-high
//   enable   1 = doubled output, 0 = bypass
//   ce_pix2  output pixel enable, two pulses per input pixel
//   vin      input stream (ce_pix, RGB, hsync/vsync, hblank/vblank)
//   vout     output stream; vout.ce_pix is the selected pixel enable
module amstrad_scandoubler #(
    parameter int LINE_W = 1024,
    parameter int AW     = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    ce_pix2,
    amstrad_scandoubler_if.slave    vin,
    amstrad_scandoubler_if.master   vout
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(LINE_W - 1);
    localparam logic [AW:0]   FULL_LEN  = (AW+1)'(LINE_W);

    // Two banks of {hblank, red, green, blue}
    logic [6:0] mem [2][LINE_W];

    // Write side state
    logic          hs_prev_q,   hs_prev_d;
    logic [AW-1:0] wcnt_q,      wcnt_d;
    logic          full_q,      full_d;
    logic          wbank_q,     wbank_d;
    logic [AW:0]   line_len_q,  line_len_d;
    logic [7:0]    hs_w_q,      hs_w_d;
    logic [7:0]    hs_len_q,    hs_len_d;
    logic          seen_edge_q, seen_edge_d;
    logic          valid_q,     valid_d;

    // Read side state
    logic [AW-1:0] rcnt_q,      rcnt_d;
    logic          vs_line_q,   vs_line_d;
    logic          vb_line_q,   vb_line_d;
    logic          vld_p1_q,    vld_p1_d;
    logic          hs_p1_q,     hs_p1_d;
    logic [6:0]    rdat_p1_q;

    // Output registers
    logic [1:0]    red_q,   red_d;
    logic [1:0]    green_q, green_d;
    logic [1:0]    blue_q,  blue_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          ce_out_q, ce_out_d;

    logic          hs_rise;
    logic          we;
    logic          wsel;
    logic [AW-1:0] waddr;
    logic [6:0]    wdata;
    logic          blank;

    assign hs_rise = vin.ce_pix & vin.hsync & ~hs_prev_q;
    assign wdata   = {vin.hblank, vin.red, vin.green, vin.blue};

    // Capture: the hsync edge pixel opens the new bank at address 0, so the
    // stored count is wcnt unless the last address was already written.
    always_comb begin
        hs_prev_d   = hs_prev_q;
        wcnt_d      = wcnt_q;
        full_d      = full_q;
        wbank_d     = wbank_q;
        line_len_d  = line_len_q;
        hs_w_d      = hs_w_q;
        hs_len_d    = hs_len_q;
        seen_edge_d = seen_edge_q;
        valid_d     = valid_q;
        we          = 1'b0;
        wsel        = wbank_q;
        waddr       = wcnt_q;
        if (vin.ce_pix) begin
            hs_prev_d = vin.hsync;
            if (hs_rise) begin
                line_len_d  = full_q ? FULL_LEN : {1'b0, wcnt_q};
                wbank_d     = ~wbank_q;
                wsel        = ~wbank_q;
                waddr       = '0;
                we          = 1'b1;
                wcnt_d      = AW'(1);
                full_d      = 1'b0;
                hs_len_d    = hs_w_q;
                hs_w_d      = 8'd1;
                seen_edge_d = 1'b1;
                valid_d     = valid_q | seen_edge_q;
            end else begin
                if (!full_q) begin
                    we = 1'b1;
                    if (wcnt_q == LAST_ADDR) begin
                        full_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + AW'(1);
                    end
                end
                if (vin.hsync && hs_w_q != 8'hFF) begin
                    hs_w_d = hs_w_q + 8'd1;
                end
            end
        end
    end

    // Replay: rcnt wraps at the captured length (two output lines per input
    // line); an input hsync edge always wins and restarts the output line.
    always_comb begin
        rcnt_d    = rcnt_q;
        vs_line_d = vs_line_q;
        vb_line_d = vb_line_q;
        vld_p1_d  = ce_pix2;
        hs_p1_d   = (AW+8)'(rcnt_q) < (AW+8)'(hs_len_q);
        if (ce_pix2 && rcnt_q == '0) begin
            vs_line_d = vin.vsync;
            vb_line_d = vin.vblank;
        end
        if (hs_rise) begin
            rcnt_d = '0;
        end else if (ce_pix2) begin
            if ({1'b0, rcnt_q} == line_len_q - (AW+1)'(1)) begin
                rcnt_d = '0;
            end else begin
                rcnt_d = rcnt_q + AW'(1);
            end
        end
    end

    // Output selection: bypass copies inputs on ce_pix, doubled mode takes
    // the buffer word read one clk earlier.
    always_comb begin
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        ce_out_d = enable ? ce_pix2 : vin.ce_pix;
        blank    = rdat_p1_q[6] | vb_line_q;
        if (!enable) begin
            if (vin.ce_pix) begin
                red_d    = vin.red;
                green_d  = vin.green;
                blue_d   = vin.blue;
                hsync_d  = vin.hsync;
                vsync_d  = vin.vsync;
                hblank_d = vin.hblank;
                vblank_d = vin.vblank;
            end
        end else if (vld_p1_q) begin
            if (!valid_q) begin
                red_d    = 2'b00;
                green_d  = 2'b00;
                blue_d   = 2'b00;
                hsync_d  = 1'b0;
                vsync_d  = 1'b0;
                hblank_d = 1'b1;
                vblank_d = 1'b1;
            end else begin
                red_d    = blank ? 2'b00 : rdat_p1_q[5:4];
                green_d  = blank ? 2'b00 : rdat_p1_q[3:2];
                blue_d   = blank ? 2'b00 : rdat_p1_q[1:0];
                hsync_d  = hs_p1_q;
                vsync_d  = vs_line_q;
                hblank_d = rdat_p1_q[6];
                vblank_d = vb_line_q;
            end
        end
    end

    // Stage p0 -> p1: buffer access and per-pixel sync info
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wsel][waddr] <= wdata;
        end
        if (ce_pix2) begin
            rdat_p1_q <= mem[~wbank_q][rcnt_q];
        end
        hs_p1_q <= hs_p1_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_prev_q   <= 1'b0;
            wcnt_q      <= '0;
            full_q      <= 1'b0;
            wbank_q     <= 1'b0;
            line_len_q  <= '0;
            hs_w_q      <= '0;
            hs_len_q    <= '0;
            seen_edge_q <= 1'b0;
            valid_q     <= 1'b0;
            rcnt_q      <= '0;
            vs_line_q   <= 1'b0;
            vb_line_q   <= 1'b1;
            vld_p1_q    <= 1'b0;
        end else begin
            hs_prev_q   <= hs_prev_d;
            wcnt_q      <= wcnt_d;
            full_q      <= full_d;
            wbank_q     <= wbank_d;
            line_len_q  <= line_len_d;
            hs_w_q      <= hs_w_d;
            hs_len_q    <= hs_len_d;
            seen_edge_q <= seen_edge_d;
            valid_q     <= valid_d;
            rcnt_q      <= rcnt_d;
            vs_line_q   <= vs_line_d;
            vb_line_q   <= vb_line_d;
            vld_p1_q    <= vld_p1_d;
        end
    end

    // Stage p1 -> output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            red_q    <= 2'b00;
            green_q  <= 2'b00;
            blue_q   <= 2'b00;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            ce_out_q <= 1'b0;
        end else begin
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            ce_out_q <= ce_out_d;
        end
    end

    assign vout.ce_pix = ce_out_q;
    assign vout.red    = red_q;
    assign vout.green  = green_q;
    assign vout.blue   = blue_q;
    assign vout.hsync  = hsync_q;
    assign vout.vsync  = vsync_q;
    assign vout.hblank = hblank_q;
    assign vout.vblank = vblank_q;

endmodule

// File: tb/tb_amstrad_scandoubler.sv
// Self-checking bench for amstrad_scandoubler. Input pixels last 4 clks
// (ce_pix on the first, ce_pix2 on the second and fourth). A line-level
// reference model keeps the previous input line as a list of pixels and
// predicts each doubled output pixel from its position in the output line.
module tb_amstrad_scandoubler;
    localparam int LINE_W = 1024;
    localparam int AW     = 10;
    localparam logic [9:0] RST_VEC = 10'b0000000011;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic ce_pix2 = 1'b0;

    amstrad_scandoubler_if vin();
    amstrad_scandoubler_if vout();

    amstrad_scandoubler #(.LINE_W(LINE_W), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .ce_pix2 (ce_pix2),
        .vin     (vin),
        .vout    (vout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic [6:0] cur_line[$];
    logic [6:0] prev_line[$];
    int         m_hs_len;
    int         m_pulse;
    int         m_k;
    int         m_edges;
    logic       m_hs_prev;
    logic       m_vs;
    logic       m_vb;
    logic       pend;
    logic [9:0] pend_exp;
    logic       sync_ok;
    logic       vs_lvl = 1'b0;

    function automatic logic [9:0] outvec();
        return {vout.red, vout.green, vout.blue, vout.hsync, vout.vsync, vout.hblank, vout.vblank};
    endfunction

    function automatic logic [9:0] invec();
        return {vin.red, vin.green, vin.blue, vin.hsync, vin.vsync, vin.hblank, vin.vblank};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        cur_line.delete();
        prev_line.delete();
        m_hs_len  = 0;
        m_pulse   = 0;
        m_k       = 0;
        m_edges   = 0;
        m_hs_prev = 1'b0;
        m_vs      = 1'b0;
        m_vb      = 1'b1;
        pend      = 1'b0;
        sync_ok   = 1'b1;
    endtask

    task automatic model_write();
        logic [6:0] p;
        p = {vin.hblank, vin.red, vin.green, vin.blue};
        if (vin.hsync && !m_hs_prev) begin
            prev_line = cur_line;
            cur_line.delete();
            cur_line.push_back(p);
            m_hs_len = m_pulse;
            m_pulse  = 1;
            m_edges++;
            m_k = 0;
        end else begin
            if (cur_line.size() < LINE_W) cur_line.push_back(p);
            if (vin.hsync && m_pulse < 255) m_pulse++;
        end
        m_hs_prev = vin.hsync;
    endtask

    task automatic model_read(input logic en);
        logic [6:0] p;
        logic [5:0] col;
        int len;
        len = prev_line.size();
        if (m_k == 0) begin
            m_vs = vin.vsync;
            m_vb = vin.vblank;
            if (en) sync_ok = 1'b1;
        end
        if (m_edges < 2 || m_k >= len) begin
            pend_exp = RST_VEC;
        end else begin
            p = prev_line[m_k];
            col = (p[6] || m_vb) ? 6'd0 : p[5:0];
            pend_exp = {col, (m_k < m_hs_len), m_vs, p[6], m_vb};
        end
        pend = sync_ok;
        if (len > 0 && m_k == len - 1) m_k = 0;
        else m_k = (m_k + 1) % (1 << AW);
    endtask

    task automatic step(input logic cp, input logic cp2);
        logic en_e;
        vin.ce_pix = cp;
        ce_pix2 = cp2;
        en_e = enable;
        @(posedge clk);
        #1;
        chk("ce_pix_out", {9'b0, vout.ce_pix}, {9'b0, (en_e ? cp2 : cp)});
        if (pend && en_e) chk("doubled", outvec(), pend_exp);
        pend = 1'b0;
        if (!en_e && cp) chk("bypass", outvec(), invec());
        if (cp) model_write();
        if (cp2) model_read(en_e);
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1;
        #1;
        chk("rst_async", outvec(), RST_VEC);
        chk("rst_async_ce", {9'b0, vout.ce_pix}, 10'd0);
        for (int i = 0; i < hold; i++) begin
            {vin.red, vin.green, vin.blue, vin.hsync, vin.vsync, vin.hblank, vin.vblank} = 10'($urandom);
            vin.ce_pix = 1'($urandom);
            ce_pix2 = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_hold", outvec(), RST_VEC);
            chk("rst_hold_ce", {9'b0, vout.ce_pix}, 10'd0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic px(input logic [5:0] col, input logic hs, input logic hb);
        {vin.red, vin.green, vin.blue} = col;
        vin.hsync  = hs;
        vin.hblank = hb;
        vin.vsync  = vs_lvl;
        vin.vblank = vs_lvl;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    // One input line; index arguments of -1 disable the corresponding event.
    task automatic line(input int npix, input int hsw, input int hbw, input int vs_on,
                        input int vs_off, input int en_at, input int rst_at, input bit rnd);
        logic [5:0] col;
        for (int n = 0; n < npix; n++) begin
            if (n == en_at) begin
                enable = ~enable;
                if (!enable) sync_ok = 1'b0;
            end
            if (n == rst_at) do_reset(2);
            if (n == vs_on) vs_lvl = 1'b1;
            if (n == vs_off) vs_lvl = 1'b0;
            col = rnd ? 6'($urandom) : 6'(n % 64);
            px(col, (n < hsw), (n < hbw));
        end
    endtask

    initial begin
        vin.ce_pix = 1'b0;
        {vin.red, vin.green, vin.blue, vin.hsync, vin.vsync, vin.hblank, vin.vblank} = '0;
        model_reset();
        enable = 1'b1;
        #2;
        do_reset(8);

        // Partial line without hsync, then counting lines 0..63
        line(20, 0, 0, -1, -1, -1, -1, 1'b0);
        repeat (4) line(64, 6, 0, -1, -1, -1, -1, 1'b0);

        // Stored hblank on pixels 0..9
        repeat (2) line(64, 6, 10, -1, -1, -1, -1, 1'b1);

        // vsync/vblank rising mid-line, held, then falling
        line(64, 6, 0, 30, -1, -1, -1, 1'b1);
        line(64, 6, 0, -1, -1, -1, -1, 1'b1);
        line(64, 6, 0, -1, 20, -1, -1, 1'b1);
        line(64, 6, 0, -1, -1, -1, -1, 1'b1);

        // Over-long lines: capture truncated at LINE_W, replay wraps
        repeat (2) line(1100, 6, 0, -1, -1, -1, -1, 1'b1);
        line(64, 6, 0, -1, -1, -1, -1, 1'b1);

        // Bypass mid-line and back
        line(64, 6, 0, -1, -1, 20, -1, 1'b1);
        line(64, 6, 0, -1, -1, 30, -1, 1'b1);
        repeat (2) line(64, 6, 0, -1, -1, -1, -1, 1'b1);

        // Reset in the middle of a line, then recovery
        line(64, 6, 0, -1, -1, -1, 30, 1'b1);
        repeat (3) line(64, 6, 3, -1, -1, -1, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/amstrad_scandoubler.md
# amstrad_scandoubler

Line-doubling video stage directly downstream of the motherboard video outputs (ce_pix, 2-bit RGB, hsync/vsync, hblank/vblank). It captures each 15 kHz input line into one bank of a two-bank line buffer. It replays the previous line twice at double pixel rate, producing a 31 kHz stream for VGA-class displays. When `enable` is low, the input stream passes through unchanged.

## Interface
Parameters:
- LINE_W, 1024, maximum captured pixels per input line; buffer depth per bank.
- AW, 10, address width; must satisfy 2^AW ≥ LINE_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = doubled output, 0 = bypass.
- ce_pix  in  1  input pixel enable (one clk pulse per input pixel).
- ce_pix2  in  1  output pixel enable; exactly 2 pulses per ce_pix period.
- red_in / green_in / blue_in  in  2 each  input colour.
- hsync_in, vsync_in, hblank_in, vblank_in  in  1 each  input sync/blank, active-high.
- ce_pix_out  out  1  output pixel enable: ce_pix2 when enable=1, ce_pix when enable=0.
- red / green / blue  out  2 each  output colour.
- hsync, vsync, hblank, vblank  out  1 each  output sync/blank, active-high.

## Operation
- Write side (acts only on ce_pix):
  - Store {hblank_in, red_in, green_in, blue_in} (7 bits) into bank `wbank` at `wcnt`, then increment `wcnt`.
  - At LINE_W-1, `wcnt` saturates; further pixels on that line are dropped.
- Hsync rising edge (sampled on ce_pix, previous sample 0, current sample 1):
  - line_len ← number of pixels stored (1..LINE_W).
  - wcnt ← 0; wbank toggles.
  - The pixel on the edge cycle is written as address 0 of the new bank.
  - hs_w counter restarts at 1.
- hs_w counts ce_pix while hsync_in=1 and saturates at 255. It is latched into hs_len on the next hsync rising edge.
- Read side (acts only on ce_pix2): read bank ~wbank at `rcnt`.
  - When rcnt = line_len-1: rcnt ← 0 and `phase` toggles (two output lines per input line).
  - Every input hsync rising edge forces rcnt ← 0 and phase ← 0 (hard resync), overriding the wrap.
- Output line timing:
  - hsync = 1 while rcnt < hs_len, giving half the input duration.
  - vsync and vblank sample vsync_in/vblank_in at each output-line start (rcnt = 0) and hold for the line.
- Colour:
  - Output colour = stored colour.
  - Forced to 0 when the stored hblank bit = 1 or latched vblank = 1.
  - hblank output = stored bit.
- Valid flag:
  - Cleared by reset; set after the second input hsync rising edge.
  - While clear: colour 0, hsync 0, vsync 0, hblank 1, vblank 1.
- Bypass (enable=0): outputs are registered copies of the inputs, updated on ce_pix. The capture logic keeps running, so the switch back to enable=1 is glitch-free at the next line.

## Timing
- Reset values: red/green/blue = 0; hsync = vsync = 0; hblank = vblank = 1; ce_pix_out = 0.
- Internal reset values: wcnt = rcnt = 0, wbank = phase = 0, line_len = 0, hs_len = 0.
- Buffer read latency is 1 clk. All outputs are registered and update on the clk following the ce_pix2 that addressed the pixel; effective latency is one ce_pix2 period.
- Pipeline alignment: hsync/hblank/vsync pass through the same pipeline stage as colour.
- Input-to-output delay is one input line plus one ce_pix2 period.
- ce_pix_out is combinational from the selected enable, delayed 1 clk to align with the data registers.
- If ce_pix and ce_pix2 are asserted in the same clk, the write and the read proceed independently (dual-port buffer; the banks differ).
- Reset mid-line: everything returns to reset values immediately. The valid flag requires two fresh hsync edges before output resumes.

## Test plan
- Reset asserted with random inputs:
  - All outputs at reset values within 0 clk (asynchronous).
  - They hold until the second hsync edge after deassertion.
- Lines of 64 ce_pix, hsync_in 6 ce_pix wide, pixel n colour = n mod 64:
  - Two output lines of 64 ce_pix2 per input line.
  - hsync high for 6 ce_pix2.
  - Colour sequence 0..63 repeated, one line late.
- Line of 1100 pixels with LINE_W=1024:
  - line_len = 1024; pixels 1024..1099 dropped.
  - Output wraps after 1024 ce_pix2, and the hsync resync still lands rcnt = 0.
- vsync_in rising mid-line N:
  - Output vsync rises at the start of the first output line after the edge.
  - Colour 0 while vblank is latched.
- Toggle enable 1→0→1:
  - enable=0: outputs equal inputs delayed 1 clk, and ce_pix_out = ce_pix.
  - Return to 1: correct doubled lines from the next output line, with no spurious hsync.
- Stored hblank bit set on pixels 0..9:
  - Output colour 0 and hblank = 1 for the first 10 ce_pix2 of both output lines.
